// File: rtl/sw_seq_if.sv
// Switch/LED bundle between the board I/O side (master) and the sequencer (slave).
interface sw_seq_if #(
    parameter int SW_W = 3
);
    logic [SW_W-1:0] sw;
    logic [SW_W-1:0] led;
    logic            step;
    logic            err;
    logic            tmo;

    modport master (output sw, input led, step, err, tmo);
    modport slave  (input sw, output led, step, err, tmo);
endinterface

// File: rtl/sw_seq_fsm.sv
// Switch-driven sequencer: IDLE plus ordered stages advanced by specific codes, with
// input stability qualification, press re-arm, wrong-code error and optional timeout.
module sw_seq_fsm #(
    parameter int SW_W        = 3,
    parameter int N_STATES    = 6,
    parameter int JUMP_STATE  = 3,
    parameter int STABLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic     clk,
    input  logic     reset,
    sw_seq_if.slave  bus
);
    localparam int SB = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam int CB = $clog2(STABLE_CYC + 1);
    localparam int TB = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [SB-1:0] { S_IDLE = '0 } state_t;

    localparam state_t          S_LAST = state_t'(N_STATES - 1);
    localparam state_t          S_JUMP = state_t'(JUMP_STATE);
    localparam logic [SW_W-1:0] C_EXIT = SW_W'(N_STATES);
    localparam logic [SW_W-1:0] C_JUMP = '1;
    localparam logic [CB-1:0]   S_MAX  = CB'(STABLE_CYC);
    localparam logic [TB-1:0]   T_LAST = TB'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              TMO_EN = (TIMEOUT_CYC > 0);

    logic [SW_W-1:0] sw_q, sw_prev;
    logic [CB-1:0]   stab, stab_n;
    logic            armed, armed_n;
    logic            accept;
    state_t          state, state_n, target;
    logic            valid, fire;
    logic            step_q, err_q, tmo_q;
    logic            step_n, err_n, tmo_n;
    logic [TB-1:0]   tcnt, tcnt_n;

    // Stability qualification and re-arm: one acceptance per press, at the cycle the
    // run length of the registered code first reaches STABLE_CYC.
    always_comb begin
        stab_n  = stab;
        armed_n = armed;
        if (sw_q == '0)
            stab_n = '0;
        else if (sw_q != sw_prev)
            stab_n = CB'(1);
        else if (stab != S_MAX)
            stab_n = stab + CB'(1);

        accept = armed && (sw_q != '0) && (stab_n == S_MAX);

        if (sw_q == '0)
            armed_n = 1'b1;
        else if (accept)
            armed_n = 1'b0;
    end

    // Next state, pulses and inactivity counter. A coincident accept discards the timeout.
    always_comb begin
        state_n = state;
        step_n  = 1'b0;
        err_n   = 1'b0;
        tmo_n   = 1'b0;
        tcnt_n  = tcnt;
        target  = state;
        valid   = 1'b0;

        if (state != S_LAST && sw_q == SW_W'(state) + SW_W'(1)) begin
            valid  = 1'b1;
            target = state_t'(state + SB'(1));
        end else if (state == S_LAST && sw_q == C_EXIT) begin
            valid  = 1'b1;
            target = S_IDLE;
        end else if (state == S_IDLE && sw_q == C_JUMP) begin
            valid  = 1'b1;
            target = S_JUMP;
        end

        fire = TMO_EN && (state != S_IDLE) && (tcnt == T_LAST);

        if (accept && valid) begin
            state_n = target;
            step_n  = 1'b1;
            tcnt_n  = '0;
        end else begin
            err_n = accept;
            if (state == S_IDLE || !TMO_EN) begin
                tcnt_n = '0;
            end else if (fire) begin
                tcnt_n = '0;
                if (!accept) begin
                    state_n = S_IDLE;
                    tmo_n   = 1'b1;
                end
            end else begin
                tcnt_n = tcnt + TB'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q    <= '0;
            sw_prev <= '0;
            stab    <= '0;
            armed   <= 1'b1;
            state   <= S_IDLE;
            tcnt    <= '0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            sw_prev <= sw_q;
            sw_q    <= bus.sw;
            stab    <= stab_n;
            armed   <= armed_n;
            state   <= state_n;
            tcnt    <= tcnt_n;
            step_q  <= step_n;
            err_q   <= err_n;
            tmo_q   <= tmo_n;
        end
    end

    assign bus.led  = SW_W'(state);
    assign bus.step = step_q;
    assign bus.err  = err_q;
    assign bus.tmo  = tmo_q;

endmodule
